// File: rtl/plic_pkg.sv
// Shared types and sizing helpers for the PLIC priority selection path.
// Node fields are sized for the largest supported configuration; narrower IDs/priorities are zero-extended.
package plic_pkg;

   localparam int ID_NONE    = 0;
   localparam int NODE_ID_W  = 16;
   localparam int NODE_PRI_W = 8;

   typedef struct packed {
      logic [NODE_ID_W-1:0]  id;
      logic [NODE_PRI_W-1:0] prio;
   } plic_node_t;

   function automatic int sources_bits(input int sources);
      return $clog2(sources + 1);
   endfunction

   function automatic int priority_bits(input int priorities);
      return (priorities <= 2) ? 1 : $clog2(priorities);
   endfunction

   function automatic int tree_depth(input int sources);
      return $clog2(sources);
   endfunction

   function automatic int pipe_latency(input int depth, input int stage_levels);
      return (depth == 0) ? 1 : (depth + stage_levels - 1) / stage_levels;
   endfunction

endpackage

// File: rtl/plic_priority_index_if.sv
// Pending/enable/priority inputs, claim strobe and winner outputs of one PLIC target selector.
interface plic_priority_index_if
   import plic_pkg::*;
#(
   parameter int SOURCES    = 8,
   parameter int PRIORITIES = 7
);
   localparam int SOURCES_BITS  = sources_bits(SOURCES);
   localparam int PRIORITY_BITS = priority_bits(PRIORITIES);

   logic [SOURCES-1:0]               src_pending_i;
   logic [SOURCES-1:0]               src_en_i;
   logic [SOURCES*PRIORITY_BITS-1:0] src_priority_i;
   logic                             claim_i;
   logic [SOURCES_BITS-1:0]          claim_id_i;
   logic [SOURCES_BITS-1:0]          id_o;
   logic [PRIORITY_BITS-1:0]         priority_o;

   modport master (
      output src_pending_i, src_en_i, src_priority_i, claim_i, claim_id_i,
      input  id_o, priority_o
   );

   modport slave (
      input  src_pending_i, src_en_i, src_priority_i, claim_i, claim_id_i,
      output id_o, priority_o
   );

endinterface

// File: rtl/plic_priority_node.sv
// 2:1 max-select of {id, priority}; the left (lower-ID) child wins on equal priority.
module plic_priority_node
   import plic_pkg::*;
(
   input  plic_node_t left_i,
   input  plic_node_t right_i,
   output plic_node_t win_o
);

   assign win_o = (right_i.prio > left_i.prio) ? right_i : left_i;

endmodule

// File: rtl/plic_priority_index.sv
// Pipelined highest-priority source selector for one PLIC target, with claim squash so a
// just-claimed source cannot leak out of stages that were filled before the claim.
module plic_priority_index
   import plic_pkg::*;
#(
   parameter int SOURCES      = 8,
   parameter int PRIORITIES   = 7,
   parameter int STAGE_LEVELS = 1
)(
   input logic                  clk,
   input logic                  rst_n,
   plic_priority_index_if.slave bus
);

   localparam int SOURCES_BITS  = sources_bits(SOURCES);
   localparam int PRIORITY_BITS = priority_bits(PRIORITIES);
   localparam int DEPTH         = tree_depth(SOURCES);
   localparam int NLEAF         = 1 << DEPTH;
   localparam int LAT           = pipe_latency(DEPTH, STAGE_LEVELS);
   localparam int CNT_W         = $clog2(LAT + 1);

   logic                    claim_vld;
   logic [CNT_W-1:0]        sq_cnt;
   logic [SOURCES_BITS-1:0] sq_id;
   logic                    squash;
   logic [NODE_ID_W-1:0]    squash_id;

   assign claim_vld = bus.claim_i && (bus.claim_id_i != SOURCES_BITS'(ID_NONE));

   // The held ID keeps squashing for LAT cycles so copies already in flight are caught at every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_cnt <= '0;
         sq_id  <= '0;
      end else if (claim_vld) begin
         sq_cnt <= CNT_W'(LAT);
         sq_id  <= bus.claim_id_i;
      end else if (sq_cnt != '0) begin
         sq_cnt <= sq_cnt - 1'b1;
      end
   end

   assign squash    = claim_vld || (sq_cnt != '0);
   assign squash_id = claim_vld ? NODE_ID_W'(bus.claim_id_i) : NODE_ID_W'(sq_id);

   // Heap-ordered tree: node 1 is the root, children of node i are 2i and 2i+1, leaves start at NLEAF.
   for (genvar i = 1; i < 2 * NLEAF; i++) begin : g_node
      localparam int HEIGHT = DEPTH - ($clog2(i + 1) - 1);

      plic_node_t comb_n;
      plic_node_t val_n;

      if (i >= NLEAF) begin : g_leaf
         localparam int SRC = i - NLEAF;
         if (SRC < SOURCES) begin : g_src
            assign comb_n = (bus.src_pending_i[SRC] && bus.src_en_i[SRC])
                          ? plic_node_t'{id:   NODE_ID_W'(SRC + 1),
                                         prio: NODE_PRI_W'(bus.src_priority_i[SRC*PRIORITY_BITS +: PRIORITY_BITS])}
                          : '0;
         end else begin : g_pad
            assign comb_n = '0;
         end
      end else begin : g_tree
         plic_priority_node u_node (
            .left_i  (g_node[2*i].val_n),
            .right_i (g_node[2*i+1].val_n),
            .win_o   (comb_n)
         );
      end

      // Stage boundary: every STAGE_LEVELS levels above the leaves, and always at the root.
      if (i == 1 || (HEIGHT > 0 && (HEIGHT % STAGE_LEVELS) == 0)) begin : g_reg
         plic_node_t node_p;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               node_p <= '0;
            else if (squash && (comb_n.id == squash_id))
               node_p <= '0;
            else
               node_p <= comb_n;
         end
         assign val_n = node_p;
      end else begin : g_wire
         assign val_n = comb_n;
      end
   end

   assign bus.id_o       = g_node[1].val_n.id[SOURCES_BITS-1:0];
   assign bus.priority_o = g_node[1].val_n.prio[PRIORITY_BITS-1:0];

   logic unused_root_hi;
   assign unused_root_hi = |{g_node[1].val_n.id[NODE_ID_W-1:SOURCES_BITS],
                             g_node[1].val_n.prio[NODE_PRI_W-1:PRIORITY_BITS]};

endmodule

// File: tb/tb_plic_priority_index.sv
// Bench for plic_priority_index: an input/claim history drives a subtree-reduction model checked every
// cycle, alongside hand-computed expectations at the interesting points of each scenario.
module tb_plic_priority_index;
   import plic_pkg::*;

   localparam int SOURCES      = 8;
   localparam int PRIORITIES   = 7;
   localparam int STAGE_LEVELS = 1;
   localparam int SB           = 4;
   localparam int PB           = 3;
   localparam int D            = 3;
   localparam int LAT          = 3;
   localparam int HMAX         = 1024;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   plic_priority_index_if #(.SOURCES(SOURCES), .PRIORITIES(PRIORITIES)) bus ();

   plic_priority_index #(
      .SOURCES      (SOURCES),
      .PRIORITIES   (PRIORITIES),
      .STAGE_LEVELS (STAGE_LEVELS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int n_edges = 0;

   logic [SOURCES-1:0]    h_pend [HMAX];
   logic [SOURCES-1:0]    h_en   [HMAX];
   logic [SOURCES*PB-1:0] h_pri  [HMAX];
   logic                  h_cl   [HMAX];
   logic [SB-1:0]         h_cid  [HMAX];
   logic                  h_rst  [HMAX];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (n_edges < HMAX) begin
         h_pend[n_edges] = bus.src_pending_i;
         h_en[n_edges]   = bus.src_en_i;
         h_pri[n_edges]  = bus.src_priority_i;
         h_cl[n_edges]   = bus.claim_i;
         h_cid[n_edges]  = bus.claim_id_i;
         h_rst[n_edges]  = rst_n;
      end
      n_edges++;
   end

   function automatic bit in_reset(input int e);
      return (e < 0) || (e >= HMAX) || !h_rst[e];
   endfunction

   // Squash at edge e comes from the newest non-zero claim among the last LAT+1 edges, cut off by reset.
   function automatic void squash_at(input int e, output bit act, output int sid);
      act = 1'b0;
      sid = 0;
      for (int k = e; k >= 0 && k >= e - LAT; k--) begin
         if (!h_rst[k]) break;
         if (h_cl[k] && h_cid[k] != 0) begin
            act = 1'b1;
            sid = int'(h_cid[k]);
            break;
         end
      end
   endfunction

   function automatic void model(input int t, output int eid, output int epri);
      int c, width, lv, grp, ng, bi, bp, sid;
      int ids [8];
      int pr  [8];
      bit act;
      eid = 0;
      epri = 0;
      c = t - LAT + 1;
      for (int e = c; e <= t; e++)
         if (in_reset(e)) return;
      for (int i = 0; i < 8; i++) begin
         if (h_pend[c][i] && h_en[c][i]) begin
            ids[i] = i + 1;
            pr[i]  = int'(h_pri[c][i*PB +: PB]);
         end else begin
            ids[i] = 0;
            pr[i]  = 0;
         end
      end
      width = 8;
      for (int s = 0; s < LAT; s++) begin
         lv  = (s == LAT - 1) ? D - s * STAGE_LEVELS : STAGE_LEVELS;
         grp = 1 << lv;
         ng  = width / grp;
         squash_at(c + s, act, sid);
         for (int g = 0; g < ng; g++) begin
            bi = ids[g*grp];
            bp = pr[g*grp];
            for (int j = 1; j < grp; j++)
               if (pr[g*grp+j] > bp) begin
                  bi = ids[g*grp+j];
                  bp = pr[g*grp+j];
               end
            if (act && bi == sid) begin
               bi = 0;
               bp = 0;
            end
            ids[g] = bi;
            pr[g]  = bp;
         end
         width = ng;
      end
      eid  = ids[0];
      epri = pr[0];
   endfunction

   always @(negedge clk) begin
      int eid, epri;
      if (n_edges > 0) begin
         if (!rst_n) begin
            eid = 0;
            epri = 0;
         end else begin
            model(n_edges - 1, eid, epri);
         end
         check("model_id", int'(bus.id_o), eid);
         check("model_pri", int'(bus.priority_o), epri);
      end
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic clear_src();
      bus.src_pending_i  = '0;
      bus.src_en_i       = '0;
      bus.src_priority_i = '0;
   endtask

   task automatic set_src(input int id, input int pri, input bit on);
      bus.src_pending_i[id-1]             = on;
      bus.src_en_i[id-1]                  = on;
      bus.src_priority_i[(id-1)*PB +: PB] = PB'(pri);
   endtask

   task automatic expect_out(input string name, input int id, input int pri);
      check({name, "_id"}, int'(bus.id_o), id);
      check({name, "_pri"}, int'(bus.priority_o), pri);
   endtask

   initial begin
      clear_src();
      bus.claim_i    = 1'b0;
      bus.claim_id_i = '0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      expect_out("idle", 0, 0);

      // Latency: winner appears on the third edge after the change.
      set_src(2, 3, 1'b1);
      set_src(5, 6, 1'b1);
      tick(1);
      expect_out("lat_edge1", 0, 0);
      tick(1);
      expect_out("lat_edge2", 0, 0);
      tick(1);
      expect_out("lat_edge3", 5, 6);

      // Tie goes to the lower ID; disabling it hands over to the other.
      clear_src();
      set_src(3, 4, 1'b1);
      set_src(7, 4, 1'b1);
      tick(3);
      expect_out("tie_low", 3, 4);
      bus.src_en_i[2] = 1'b0;
      tick(2);
      expect_out("tie_hold", 3, 4);
      tick(1);
      expect_out("tie_drop", 7, 4);

      // Priority 7 is beyond the level count and compared unclipped; all-equal picks ID 1.
      clear_src();
      set_src(1, 6, 1'b1);
      set_src(8, 7, 1'b1);
      tick(3);
      expect_out("pri_max", 8, 7);
      for (int i = 1; i <= SOURCES; i++) set_src(i, 2, 1'b1);
      tick(3);
      expect_out("all_equal", 1, 2);

      // Claim of ID 0 does nothing.
      clear_src();
      set_src(5, 6, 1'b1);
      tick(3);
      bus.claim_i    = 1'b1;
      bus.claim_id_i = '0;
      tick(1);
      bus.claim_i = 1'b0;
      expect_out("claim0_next", 5, 6);
      tick(3);
      expect_out("claim0_late", 5, 6);

      // Single claim with pending dropped in the same cycle.
      clear_src();
      set_src(4, 5, 1'b1);
      tick(3);
      expect_out("pre_claim", 4, 5);
      bus.claim_i    = 1'b1;
      bus.claim_id_i = SB'(4);
      set_src(4, 5, 1'b0);
      tick(1);
      bus.claim_i = 1'b0;
      expect_out("squash_next", 0, 0);
      tick(3);
      expect_out("squash_late", 0, 0);

      // Back-to-back claims of 4 then 6 with 6 still pending.
      set_src(4, 5, 1'b1);
      set_src(6, 2, 1'b1);
      tick(3);
      expect_out("b2b_pre", 4, 5);
      bus.claim_i    = 1'b1;
      bus.claim_id_i = SB'(4);
      set_src(4, 5, 1'b0);
      tick(1);
      bus.claim_id_i = SB'(6);
      tick(1);
      bus.claim_i    = 1'b0;
      bus.claim_id_i = '0;
      expect_out("b2b_e1", 0, 0);
      tick(3);
      expect_out("b2b_e4", 0, 0);
      tick(2);
      expect_out("b2b_e6", 0, 0);
      tick(1);
      expect_out("b2b_back", 6, 2);

      // Asynchronous reset mid-stream.
      clear_src();
      set_src(5, 6, 1'b1);
      tick(3);
      expect_out("pre_rst", 5, 6);
      #2 rst_n = 1'b0;
      #1 expect_out("async_rst", 0, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      expect_out("post_rst_early", 0, 0);
      tick(1);
      expect_out("post_rst", 5, 6);
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
